// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD dispatcher and the subtractive GCD core
// (controller + datapath): FSM encodings, error codes, default width.
package gcd_pkg;

  localparam int DEFAULT_NUMBER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  typedef enum logic {
    ERR_NONE  = 1'b0,
    ERR_FAULT = 1'b1
  } err_t;

endpackage

// File: rtl/gcd_sync_fifo.sv
// Synchronous FIFO holding queued GCD jobs; pointers carry one extra wrap bit
// so full and empty are told apart by the MSB alone.
module gcd_sync_fifo
  import gcd_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Head entry comes straight from the storage registers so the consumer can
  // load it on the same edge that pops it.
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/gcd_job_dispatcher.sv
// Front end for the subtractive GCD core: queues tagged operand pairs, issues
// one job at a time, resolves zero operands locally and aborts hung jobs.
module gcd_job_dispatcher
  import gcd_pkg::*;
#(
  parameter int NUMBER_WIDTH = DEFAULT_NUMBER_WIDTH,
  parameter int DEPTH        = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int MAX_CYCLES   = 70000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUMBER_WIDTH-1:0] in_a,
  input  logic [NUMBER_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    core_start,
  output logic [NUMBER_WIDTH-1:0] core_a,
  output logic [NUMBER_WIDTH-1:0] core_b,
  input  logic                    core_done,
  input  logic [NUMBER_WIDTH-1:0] core_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUMBER_WIDTH-1:0] out_gcd,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_err,
  output logic                    busy
);

  localparam int ENTRY_WIDTH = 2*NUMBER_WIDTH + TAG_WIDTH;
  localparam int CNT_WIDTH   = $clog2(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_WIDTH-1:0]    count;
  logic [NUMBER_WIDTH-1:0] work_a;
  logic [NUMBER_WIDTH-1:0] work_b;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ENTRY_WIDTH-1:0]  fifo_head;
  logic [NUMBER_WIDTH-1:0] head_a;
  logic [NUMBER_WIDTH-1:0] head_b;
  logic [TAG_WIDTH-1:0]    head_tag;
  logic                    head_bypass;

  gcd_sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data ({in_a, in_b, in_tag}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_a, head_b, head_tag} = fifo_head;
  assign head_bypass = (head_a == '0) || (head_b == '0);
  assign in_ready    = !fifo_full;
  assign core_a      = work_a;
  assign core_b      = work_b;
  assign busy        = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_next = state;
    core_start = 1'b0;
    out_valid  = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = head_bypass ? EMIT : ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_done || (count == CNT_LIMIT)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands only reach the core for non-zero pairs; zero pairs are answered
  // here, with 0/0 flagged as an error since it has no defined GCD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      work_a  <= '0;
      work_b  <= '0;
      out_gcd <= '0;
      out_tag <= '0;
      out_err <= ERR_NONE;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            out_tag <= head_tag;
            if (head_a == '0) begin
              out_gcd <= head_b;
              out_err <= (head_b == '0) ? ERR_FAULT : ERR_NONE;
            end else if (head_b == '0) begin
              out_gcd <= head_a;
              out_err <= ERR_NONE;
            end else begin
              work_a <= head_a;
              work_b <= head_b;
            end
          end
        end
        ISSUE: count <= '0;
        WAIT: begin
          count <= count + CNT_WIDTH'(1);
          if (core_done) begin
            out_gcd <= core_res;
            out_err <= ERR_NONE;
          end else if (count == CNT_LIMIT) begin
            out_gcd <= '0;
            out_err <= ERR_FAULT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
